arm_mc_datapath: RTL and testbench

//   Multicycle ARM-subset datapath, driven cycle by cycle by the multicycle controller.
//   - Consumes the controller's enables and mux selects.
//   - Returns the instruction register (Instr) and the live ALU flags (ALUFlags) to it.
//   - Owns PC, IR, the register file and all non-architectural registers
//     (Data, A, WD, ALUOut).
//   - Drives a single unified instruction/data memory port.

---
 rtl/arm_mc_pkg.sv | 10 +
 rtl/arm_mc_datapath_if.sv | 17 +
 rtl/arm_mc_regfile.sv | 26 ++
 rtl/flopenr.sv | 12 +
 rtl/arm_mc_datapath.sv | 57 +++++
 tb/tb_arm_mc_datapath.sv | 186 ++++++++++++++++++
 6 files changed

// File: rtl/arm_mc_pkg.sv
// arm_mc_pkg: encodings and constants shared by the multicycle ARM datapath and controller
package arm_mc_pkg;
   typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR} alu_op_t;
   typedef enum logic [1:0] {IMM_8, IMM_12, IMM_BR, IMM_ZERO} imm_src_t;
   typedef enum logic [1:0] {RES_ALUOUT, RES_DATA, RES_ALU, RES_ALUOUT_ALT} result_src_t;
   typedef enum logic [1:0] {SRCA_A, SRCA_PC, SRCA_ALUOUT, SRCA_ZERO} srca_t;
   typedef enum logic [1:0] {SRCB_WD, SRCB_EXT, SRCB_FOUR, SRCB_ZERO} srcb_t;
   localparam logic [3:0] REG_PC = 4'd15;
   localparam int PC_INC = 4;
endpackage

// File: rtl/arm_mc_datapath_if.sv
// arm_mc_datapath_if: controller enables/selects plus the unified memory port of the datapath
interface arm_mc_datapath_if #(parameter int WIDTH = 32);
   logic PCWrite, RegWrite, IRWrite, AdrSrc;
   logic [1:0] RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
   logic [WIDTH-1:0] ReadData, Adr, WriteData, Instr;
   logic [3:0] ALUFlags;
   modport master (
      output PCWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
             ALUControl, ReadData,
      input  Adr, WriteData, Instr, ALUFlags
   );
   modport slave (
      input  PCWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
             ALUControl, ReadData,
      output Adr, WriteData, Instr, ALUFlags
   );
endinterface

// File: rtl/arm_mc_regfile.sv
// arm_mc_regfile: r0..r14 with two combinational reads and one synchronous write; index 15 reads the PC
module arm_mc_regfile
   import arm_mc_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NREGS = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we3,
   input  logic [3:0]       ra1,
   input  logic [3:0]       ra2,
   input  logic [3:0]       wa3,
   input  logic [WIDTH-1:0] wd3,
   input  logic [WIDTH-1:0] r15,
   output logic [WIDTH-1:0] rd1,
   output logic [WIDTH-1:0] rd2
);
   logic [WIDTH-1:0] rf [NREGS];
   // r15 writes are dropped here; the PC only moves through PCWrite
   always_ff @(posedge clk)
      if (reset) for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      else if (we3 && wa3 != REG_PC) rf[wa3] <= wd3;
   assign rd1 = ra1 == REG_PC ? r15 : rf[ra1];
   assign rd2 = ra2 == REG_PC ? r15 : rf[ra2];
endmodule

// File: rtl/flopenr.sv
// flopenr: enabled register with synchronous active-high reset
module flopenr #(parameter int WIDTH = 32) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   always_ff @(posedge clk)
      if (reset) q <= '0;
      else if (en) q <= d;
endmodule

// File: rtl/arm_mc_datapath.sv
// arm_mc_datapath: multicycle ARM-subset datapath (PC, IR, regfile, extender, ALU, staging registers)
module arm_mc_datapath
   import arm_mc_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NREGS = 15
) (
   input logic clk,
   input logic reset,
   arm_mc_datapath_if.slave bus
);
   logic [WIDTH-1:0] pc, instr, data, a, wd, alu_out, rd1, rd2;
   logic [WIDTH-1:0] ext_imm, src_a, src_b, b_x, alu_result, result;
   logic [WIDTH:0] sum;
   logic [3:0] ra1, ra2, flags;
   logic sub, arith;
   flopenr #(WIDTH) pc_reg   (.clk, .reset, .en(bus.PCWrite), .d(result),       .q(pc));
   flopenr #(WIDTH) ir_reg   (.clk, .reset, .en(bus.IRWrite), .d(bus.ReadData), .q(instr));
   flopenr #(WIDTH) data_reg (.clk, .reset, .en(1'b1),        .d(bus.ReadData), .q(data));
   flopenr #(WIDTH) a_reg    (.clk, .reset, .en(1'b1),        .d(rd1),          .q(a));
   flopenr #(WIDTH) wd_reg   (.clk, .reset, .en(1'b1),        .d(rd2),          .q(wd));
   flopenr #(WIDTH) alu_reg  (.clk, .reset, .en(1'b1),        .d(alu_result),   .q(alu_out));
   assign ra1 = bus.RegSrc[0] ? REG_PC : instr[19:16];
   assign ra2 = bus.RegSrc[1] ? instr[15:12] : instr[3:0];
   arm_mc_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) rf (
      .clk, .reset, .we3(bus.RegWrite), .ra1, .ra2, .wa3(instr[15:12]),
      .wd3(result), .r15(pc), .rd1, .rd2
   );
   always_comb begin
      ext_imm = bus.ImmSrc == IMM_8  ? {{(WIDTH-8){1'b0}}, instr[7:0]} :
                bus.ImmSrc == IMM_12 ? {{(WIDTH-12){1'b0}}, instr[11:0]} :
                bus.ImmSrc == IMM_BR ? {{(WIDTH-26){instr[23]}}, instr[23:0], 2'b00} : '0;
      src_a = bus.ALUSrcA == SRCA_A      ? a :
              bus.ALUSrcA == SRCA_PC     ? pc :
              bus.ALUSrcA == SRCA_ALUOUT ? alu_out : '0;
      src_b = bus.ALUSrcB == SRCB_WD   ? wd :
              bus.ALUSrcB == SRCB_EXT  ? ext_imm :
              bus.ALUSrcB == SRCB_FOUR ? WIDTH'(PC_INC) : '0;
   end
   // SUB shares the adder as A + ~B + 1 so carry reads as "no borrow"
   always_comb begin
      sub = bus.ALUControl == ALU_SUB;
      arith = bus.ALUControl == ALU_ADD || sub;
      b_x = sub ? ~src_b : src_b;
      sum = {1'b0, src_a} + {1'b0, b_x} + {{WIDTH{1'b0}}, sub};
      alu_result = bus.ALUControl == ALU_AND ? src_a & src_b :
                   bus.ALUControl == ALU_ORR ? src_a | src_b : sum[WIDTH-1:0];
      flags = {alu_result[WIDTH-1], alu_result == '0, arith & sum[WIDTH],
               arith & (src_a[WIDTH-1] == b_x[WIDTH-1]) & (alu_result[WIDTH-1] != src_a[WIDTH-1])};
      result = bus.ResultSrc == RES_DATA ? data :
               bus.ResultSrc == RES_ALU  ? alu_result : alu_out;
   end
   assign bus.Adr = bus.AdrSrc ? result : pc;
   assign bus.WriteData = wd;
   assign bus.Instr = instr;
   assign bus.ALUFlags = flags;
endmodule

// File: tb/tb_arm_mc_datapath.sv
// tb_arm_mc_datapath: directed vector table plus randomized cycles against an arithmetic reference model
module tb_arm_mc_datapath;
   logic clk = 1'b0;
   logic reset;
   int checks = 0;
   int errors = 0;
   arm_mc_datapath_if #(.WIDTH(32)) bus ();
   arm_mc_datapath dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;

   // control word: {rst, PCWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl}
   localparam logic [16:0] RST = 17'h10000, PCW = 17'h08000, RW = 17'h04000, IRW = 17'h02000;
   localparam logic [16:0] AS = 17'h01000, RG_PC = 17'h00400, RG_RD = 17'h00800;
   localparam logic [16:0] SA_A = 17'h0, SA_PC = 17'h100, SA_AO = 17'h200, SA_Z = 17'h300;
   localparam logic [16:0] SB_WD = 17'h0, SB_EXT = 17'h040, SB_4 = 17'h080, SB_Z = 17'h0C0;
   localparam logic [16:0] RS_AO = 17'h0, RS_DATA = 17'h010, RS_ALU = 17'h020;
   localparam logic [16:0] IMMBR = 17'h008, OP_SUB = 17'h001;
   localparam logic [16:0] FIX = PCW | SA_PC | SB_4 | RS_ALU;
   localparam logic [3:0] K_ADR = 4'h8, K_WD = 4'h4, K_INS = 4'h2, K_FL = 4'h1;

   typedef struct {
      string       name;
      logic [16:0] c;
      logic [31:0] rd;
      logic [3:0]  ck;
      logic [31:0] adr, wd, ins;
      logic [3:0]  fl;
   } vec_t;
   vec_t vq[$];

   logic [31:0] m_pc, m_ir, m_data, m_a, m_wd, m_aluout;
   logic [31:0] m_rf [15];
   bit mvalid = 0;

   function automatic void add(input string n, input logic [16:0] c, input logic [31:0] rd,
                               input logic [3:0] ck, input logic [31:0] adr, wd, ins, input logic [3:0] fl);
      vq.push_back('{n, c, rd, ck, adr, wd, ins, fl});
   endfunction

   function automatic logic [31:0] ref_reg(input int i);
      return i == 15 ? m_pc : m_rf[i];
   endfunction

   function automatic logic [31:0] ref_ext(input logic [31:0] ir, input logic [1:0] sel);
      logic signed [31:0] off;
      off = $signed(ir[23:0]);
      case (sel)
         2'd0: return {24'h0, ir[7:0]};
         2'd1: return {20'h0, ir[11:0]};
         2'd2: return off * 4;
         default: return 32'h0;
      endcase
   endfunction

   // flags from wide integer arithmetic: carry = bit out of 32, overflow = true sum not representable
   function automatic logic [35:0] ref_alu(input logic [31:0] a, b, input logic [1:0] op);
      longint unsigned ua, ub;
      longint sa, sb, sr;
      logic [31:0] r;
      logic c, v;
      ua = a; ub = b; sa = $signed(a); sb = $signed(b);
      c = 0; v = 0; sr = 0;
      case (op)
         2'd0: begin r = a + b; c = ((ua + ub) >> 32) != 0; sr = sa + sb; v = sr != longint'($signed(r)); end
         2'd1: begin r = a - b; c = ua >= ub; sr = sa - sb; v = sr != longint'($signed(r)); end
         2'd2: r = a & b;
         default: r = a | b;
      endcase
      return {r[31], r == 32'h0, c, v, r};
   endfunction

   task automatic check(input string n, input logic [31:0] act, exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   task automatic cycle(input vec_t v);
      logic [31:0] ext, sa, sb, res, adr, n_a, n_wd;
      logic [35:0] ar;
      int ra1, ra2, rd_idx;
      reset = v.c[16];
      bus.PCWrite = v.c[15]; bus.RegWrite = v.c[14]; bus.IRWrite = v.c[13]; bus.AdrSrc = v.c[12];
      bus.RegSrc = v.c[11:10]; bus.ALUSrcA = v.c[9:8]; bus.ALUSrcB = v.c[7:6];
      bus.ResultSrc = v.c[5:4]; bus.ImmSrc = v.c[3:2]; bus.ALUControl = v.c[1:0];
      bus.ReadData = v.rd;
      @(negedge clk);
      ext = ref_ext(m_ir, v.c[3:2]);
      case (v.c[9:8])
         2'd0: sa = m_a;
         2'd1: sa = m_pc;
         2'd2: sa = m_aluout;
         default: sa = 0;
      endcase
      case (v.c[7:6])
         2'd0: sb = m_wd;
         2'd1: sb = ext;
         2'd2: sb = 4;
         default: sb = 0;
      endcase
      ar = ref_alu(sa, sb, v.c[1:0]);
      res = v.c[5:4] == 2'd1 ? m_data : v.c[5:4] == 2'd2 ? ar[31:0] : m_aluout;
      adr = v.c[12] ? res : m_pc;
      if (v.ck[3]) check({v.name, " adr"}, bus.Adr, v.adr);
      if (v.ck[2]) check({v.name, " wdata"}, bus.WriteData, v.wd);
      if (v.ck[1]) check({v.name, " instr"}, bus.Instr, v.ins);
      if (v.ck[0]) check({v.name, " flags"}, {28'h0, bus.ALUFlags}, {28'h0, v.fl});
      if (mvalid) begin
         check({v.name, " model adr"}, bus.Adr, adr);
         check({v.name, " model wdata"}, bus.WriteData, m_wd);
         check({v.name, " model instr"}, bus.Instr, m_ir);
         check({v.name, " model flags"}, {28'h0, bus.ALUFlags}, {28'h0, ar[35:32]});
      end
      ra1 = v.c[10] ? 15 : int'(m_ir[19:16]);
      ra2 = v.c[11] ? int'(m_ir[15:12]) : int'(m_ir[3:0]);
      rd_idx = int'(m_ir[15:12]);
      n_a = ref_reg(ra1);
      n_wd = ref_reg(ra2);
      @(posedge clk);
      if (v.c[16]) begin
         m_pc = 0; m_ir = 0; m_data = 0; m_a = 0; m_wd = 0; m_aluout = 0;
         for (int i = 0; i < 15; i++) m_rf[i] = 0;
         mvalid = 1;
      end else begin
         if (v.c[14] && rd_idx != 15) m_rf[rd_idx] = res;
         if (v.c[15]) m_pc = res;
         if (v.c[13]) m_ir = v.rd;
         m_data = v.rd; m_a = n_a; m_wd = n_wd; m_aluout = ar[31:0];
      end
      #1;
   endtask

   initial begin
      vec_t r;
      add("reset",    RST, 0, 0, 0, 0, 0, 0);
      add("pc0",      FIX, 0, K_ADR | K_WD | K_INS, 32'h0, 32'h0, 32'h0, 0);
      add("pc4",      FIX, 0, K_ADR, 32'h4, 0, 0, 0);
      add("pc8",      FIX, 0, K_ADR, 32'h8, 0, 0, 0);
      add("pcc",      0, 32'h7, K_ADR, 32'hC, 0, 0, 0);
      add("wr_r0",    RW | RS_DATA, 0, K_ADR, 32'hC, 0, 0, 0);
      add("fetch",    IRW, 32'hE280_1005, K_INS, 0, 0, 32'h0, 0);
      add("ext8",     AS | RS_ALU | SA_Z | SB_EXT, 0, K_ADR | K_INS, 32'h5, 0, 32'hE280_1005, 0);
      add("add",      AS | RS_ALU | SA_A | SB_EXT, 0, K_ADR | K_FL, 32'hC, 0, 0, 4'b0000);
      add("wr_r1",    AS | RW | RS_AO, 0, K_ADR, 32'hC, 0, 0, 0);
      add("rd_r1",    RG_RD, 0, 0, 0, 0, 0, 0);
      add("wd_r1",    SA_Z | SB_EXT, 0, K_WD, 0, 32'hC, 0, 0);
      add("sub_z",    SA_AO | SB_EXT | OP_SUB, 32'h7FFF_FFFF, K_FL, 0, 0, 0, 4'b0110);
      add("wr_max",   RW | RS_DATA, 0, 0, 0, 0, 0, 0);
      add("fetch2",   IRW, 32'h0001_0000, 0, 0, 0, 0, 0);
      add("data1",    0, 32'h1, K_INS, 0, 0, 32'h0001_0000, 0);
      add("wr_r0b",   RW | RS_DATA, 0, 0, 0, 0, 0, 0);
      add("rd_ops",   0, 0, 0, 0, 0, 0, 0);
      add("add_v",    SA_A | SB_WD, 0, K_WD | K_FL, 0, 32'h1, 0, 4'b1001);
      add("ld100",    0, 32'h100, 0, 0, 0, 0, 0);
      add("br_fetch", PCW | RS_DATA | IRW, 32'hEAFF_FFFE, 0, 0, 0, 0, 0);
      add("branch",   PCW | SA_PC | SB_EXT | IMMBR | RS_ALU, 0, K_ADR | K_INS | K_FL, 32'h100, 0, 32'hEAFF_FFFE, 4'b0010);
      add("br_pc",    IRW, 32'hE580_3000, K_ADR, 32'hF8, 0, 0, 0);
      add("st_data",  0, 32'hDEAD_BEEF, K_INS, 0, 0, 32'hE580_3000, 0);
      add("wr_r3",    RW | RS_DATA, 0, 0, 0, 0, 0, 0);
      add("rd_r3",    RG_RD | SA_PC | SB_4, 0, 0, 0, 0, 0, 0);
      add("store",    AS | RS_AO, 0, K_ADR | K_WD, 32'hFC, 32'hDEAD_BEEF, 0, 0);
      add("fetch15",  IRW, 32'hE000_F000, 0, 0, 0, 0, 0);
      add("wr_r15",   RW | RS_ALU | SA_Z | SB_4, 0, K_INS, 0, 0, 32'hE000_F000, 0);
      add("pc_keep",  0, 0, K_ADR, 32'hF8, 0, 0, 0);
      add("r0_keep",  RG_PC | AS | RS_ALU | SA_A | SB_Z, 0, K_ADR, 32'h1, 0, 0, 0);
      add("mid_rst",  RST | PCW | RW | IRW | AS | RS_ALU | SA_A | SB_Z, 32'h1234_5678, K_ADR, 32'hF8, 0, 0, 0);
      add("post_rst", SA_AO | SB_Z, 0, K_ADR | K_WD | K_INS | K_FL, 32'h0, 32'h0, 32'h0, 4'b0100);
      add("r0_clr",   AS | RS_ALU | SA_A | SB_Z, 32'hFFFF_FFFC, K_ADR, 32'h0, 0, 0, 0);
      add("ld_top",   PCW | RS_DATA, 0, K_ADR, 32'h0, 0, 0, 0);
      add("wrap",     FIX, 0, K_ADR | K_FL, 32'hFFFF_FFFC, 0, 0, 4'b0110);
      add("wrapped",  0, 0, K_ADR, 32'h0, 0, 0, 0);
      foreach (vq[i]) cycle(vq[i]);
      r = '{"rnd", RST, 0, 0, 0, 0, 0, 0};
      cycle(r);
      for (int i = 0; i < 400; i++) begin
         r.c = 17'($urandom);
         r.c[16] = $urandom_range(0, 39) == 0;
         r.rd = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 8)) : $urandom;
         cycle(r);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
